// File: rtl/pc_sequencer.sv
// Control sequencer for the rudimentary processor: decodes the fetched instruction,
// drives PC load/hold and datapath enables, squashes wrong-path fetches and stalls on memory.
module pc_sequencer #(
   parameter int BUS_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] instr,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 PL,
   output logic                 JB,
   output logic [5:0]           offset,
   output logic                 pc_hold,
   output logic                 rf_we,
   output logic [2:0]           dr_addr,
   output logic [2:0]           sa_addr,
   output logic [2:0]           sb_addr,
   output logic [3:0]           alu_func,
   output logic                 imm_sel,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 halted,
   output logic                 illegal
);

   typedef enum logic [2:0] {
      S_START,
      S_EXEC,
      S_MEM_WAIT,
      S_FLUSH,
      S_HALT
   } state_t;

   localparam logic [2:0] OP_ALU  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_LD   = 3'b010;
   localparam logic [2:0] OP_ST   = 3'b011;
   localparam logic [2:0] OP_BRZ  = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;

   state_t     state_q, state_d;
   logic       st_q, st_d;
   logic       illegal_q, illegal_d;
   logic [2:0] opcode;

   assign opcode = instr[15:13];

   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      illegal_d = illegal_q;
      PL        = 1'b0;
      JB        = 1'b0;
      offset    = 6'd0;
      pc_hold   = 1'b0;
      rf_we     = 1'b0;
      alu_func  = 4'h0;
      imm_sel   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      dr_addr   = instr[8:6];
      sa_addr   = instr[5:3];
      sb_addr   = instr[2:0];

      case (state_q)
         S_START: state_d = S_EXEC;

         S_EXEC: begin
            offset = {instr[8:6], instr[2:0]};
            case (opcode)
               OP_ALU: begin
                  rf_we    = 1'b1;
                  alu_func = instr[12:9];
               end
               OP_LDI: begin
                  rf_we   = 1'b1;
                  imm_sel = 1'b1;
               end
               OP_LD, OP_ST: begin
                  mem_req = 1'b1;
                  pc_hold = 1'b1;
                  mem_we  = (opcode == OP_ST);
                  st_d    = (opcode == OP_ST);
                  state_d = S_MEM_WAIT;
               end
               OP_BRZ: begin
                  PL = zero;
                  if (zero) state_d = S_FLUSH;
               end
               OP_JMP: begin
                  PL      = 1'b1;
                  JB      = 1'b1;
                  state_d = S_FLUSH;
               end
               OP_HALT: state_d = S_HALT;
               default: illegal_d = 1'b1;
            endcase
         end

         // Instruction register is frozen here, so the remembered LD/ST kind stays valid.
         S_MEM_WAIT: begin
            mem_req = 1'b1;
            mem_we  = st_q;
            pc_hold = ~mem_ready;
            if (mem_ready) begin
               rf_we   = ~st_q;
               state_d = S_EXEC;
            end
         end

         S_FLUSH: state_d = S_EXEC;

         S_HALT: pc_hold = 1'b1;

         default: state_d = S_START;
      endcase
   end

   assign halted  = (state_q == S_HALT);
   assign illegal = illegal_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_START;
         st_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         st_q      <= st_d;
         illegal_q <= illegal_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a decode table plus hand-written multi-cycle sequences.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        PL, JB, pc_hold, rf_we, imm_sel, mem_req, mem_we, halted, illegal;
   logic [5:0]  offset;
   logic [2:0]  dr_addr, sa_addr, sb_addr;
   logic [3:0]  alu_func;

   int n_tests = 0;
   int n_fail  = 0;

   pc_sequencer #(.BUS_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .PL(PL), .JB(JB), .offset(offset), .pc_hold(pc_hold), .rf_we(rf_we),
      .dr_addr(dr_addr), .sa_addr(sa_addr), .sb_addr(sb_addr), .alu_func(alu_func),
      .imm_sel(imm_sel), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   // {PL, JB, offset, pc_hold, rf_we, imm_sel, alu_func, mem_req, mem_we, halted, illegal}
   function automatic logic [18:0] pk(input logic pl, input logic jb, input logic [5:0] off,
                                      input logic hold, input logic we, input logic imm,
                                      input logic [3:0] alu, input logic mreq, input logic mwe,
                                      input logic hlt, input logic ill);
      return {pl, jb, off, hold, we, imm, alu, mreq, mwe, hlt, ill};
   endfunction

   function automatic logic [18:0] outs();
      return {PL, JB, offset, pc_hold, rf_we, imm_sel, alu_func, mem_req, mem_we, halted, illegal};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive inputs just after a rising edge, check at the falling edge, then cross the next rising edge.
   task automatic vec(input string nm, input logic [15:0] i, input logic z, input logic rdy,
                      input logic [18:0] exp);
      instr = i; zero = z; mem_ready = rdy;
      @(negedge clk);
      chk(nm, {13'd0, outs()}, {13'd0, exp});
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] instr;
      logic        zero;
      logic [18:0] exp;
   } vec_t;

   localparam logic [18:0] ZERO_O = 19'd0;
   logic [18:0] alu_o;

   initial begin
      vec_t tbl[5];
      alu_o = pk(0,0,6'd0,0,1,0,4'h0,0,0,0,0);

      tbl[0] = '{16'h0000, 1'b0, alu_o};
      tbl[1] = '{16'h1E3A, 1'b0, pk(0,0,6'h02,0,1,0,4'hF,0,0,0,0)};
      tbl[2] = '{16'h2005, 1'b0, pk(0,0,6'h05,0,1,1,4'h0,0,0,0,0)};
      tbl[3] = '{16'h81C7, 1'b0, pk(0,0,6'h3F,0,0,0,4'h0,0,0,0,0)};
      tbl[4] = '{16'h0400, 1'b1, pk(0,0,6'h00,0,1,0,4'h2,0,0,0,0)};

      reset = 1'b0; instr = 16'h0000; zero = 1'b0; mem_ready = 1'b0;
      vec("reset_outputs", 16'h0000, 0, 0, ZERO_O);
      reset = 1'b1;
      vec("start_cycle", 16'h0000, 0, 0, ZERO_O);
      vec("first_exec", 16'h0000, 0, 0, alu_o);
      vec("alu_stream1", 16'h0000, 0, 1, alu_o);   // stray mem_ready outside MEM_WAIT
      vec("alu_stream2", 16'h0000, 0, 0, alu_o);

      for (int k = 0; k < 5; k++) begin
         instr = tbl[k].instr; zero = tbl[k].zero; mem_ready = 1'b0;
         @(negedge clk);
         chk($sformatf("table[%0d]", k), {13'd0, outs()}, {13'd0, tbl[k].exp});
         @(posedge clk);
         #1;
      end

      // Taken BRZ, then FLUSH, then target in EXEC
      vec("brz_taken", 16'h81C7, 1, 0, pk(1,0,6'h3F,0,0,0,4'h0,0,0,0,0));
      vec("brz_flush", 16'h0000, 1, 0, ZERO_O);
      vec("brz_target", 16'h0000, 0, 0, alu_o);
      vec("brz_untaken", 16'h81C7, 0, 0, pk(0,0,6'h3F,0,0,0,4'h0,0,0,0,0));
      vec("brz_no_flush", 16'h0000, 0, 0, alu_o);

      // JMP with register address check, then a JMP sitting in FLUSH is squashed
      instr = 16'hA018;
      @(negedge clk);
      chk("jmp_sa_addr", {29'd0, sa_addr}, 32'd3);
      chk("jmp_ctrl", {13'd0, outs()}, {13'd0, pk(1,1,6'h00,0,0,0,4'h0,0,0,0,0)});
      @(posedge clk); #1;
      vec("jmp_in_flush", 16'hA018, 0, 0, ZERO_O);
      vec("jmp_again", 16'hA018, 0, 0, pk(1,1,6'h00,0,0,0,4'h0,0,0,0,0));
      vec("jmp_flush2", 16'h0000, 0, 0, ZERO_O);
      vec("jmp_target", 16'h0000, 0, 0, alu_o);

      // LD with three wait cycles
      vec("ld_exec", 16'h4040, 0, 0, pk(0,0,6'h08,1,0,0,4'h0,1,0,0,0));
      for (int w = 0; w < 3; w++)
         vec($sformatf("ld_wait%0d", w), 16'h4040, 0, 0, pk(0,0,6'h00,1,0,0,4'h0,1,0,0,0));
      vec("ld_ready", 16'h4040, 0, 1, pk(0,0,6'h00,0,1,0,4'h0,1,0,0,0));
      vec("ld_resume", 16'h0000, 0, 0, alu_o);

      // ST with immediate ready
      vec("st_exec", 16'h6000, 0, 0, pk(0,0,6'h00,1,0,0,4'h0,1,1,0,0));
      vec("st_ready", 16'h6000, 0, 1, pk(0,0,6'h00,0,0,0,4'h0,1,1,0,0));
      vec("st_resume", 16'h0000, 0, 0, alu_o);

      // Reset asserted in the middle of MEM_WAIT
      vec("ld2_exec", 16'h4040, 0, 0, pk(0,0,6'h08,1,0,0,4'h0,1,0,0,0));
      @(negedge clk);
      chk("ld2_wait_req", {31'd0, mem_req}, 32'd1);
      #2 reset = 1'b0;
      #1 chk("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      vec("ld2_start", 16'h0000, 0, 0, ZERO_O);
      vec("ld2_exec_again", 16'h0000, 0, 0, alu_o);

      // Illegal opcode is a sticky NOP
      vec("illegal_exec", 16'hE000, 0, 0, ZERO_O);
      vec("illegal_sticky1", 16'h0000, 0, 0, pk(0,0,6'd0,0,1,0,4'h0,0,0,0,1));
      vec("illegal_sticky2", 16'h2005, 0, 0, pk(0,0,6'h05,0,1,1,4'h0,0,0,0,1));

      // HALT holds regardless of instr, zero or mem_ready
      vec("halt_exec", 16'hC000, 0, 0, pk(0,0,6'd0,0,0,0,4'h0,0,0,0,1));
      for (int h = 0; h < 12; h++)
         vec($sformatf("halt_hold%0d", h), (h % 3 == 0) ? 16'h81C7 : ((h % 3 == 1) ? 16'hA018 : 16'h4040),
             1'b1, 1'b1, pk(0,0,6'd0,1,0,0,4'h0,0,0,1,1));

      // Reset pulse leaves HALT and clears sticky status
      #2 reset = 1'b0;
      #1 chk("halt_reset_outputs", {13'd0, outs()}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      vec("post_halt_start", 16'h0000, 0, 0, ZERO_O);
      vec("post_halt_exec", 16'h0000, 0, 0, alu_o);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
